countdown_timer: RTL



---
 rtl/countdown_timer.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: keypad-loaded BCD MM:SS countdown with a one-second
// prescaler, start/pause/cancel control and a one-cycle done pulse.
// Optional build macro TIMER_ADD30_EN: start adds 30 s (loads 0:30 from zero).
// Ports: clock, clearn (async active-low reset); digit/digit_valid shift in
//   a keypad digit; start/pause/cancel controls; sec_ones/sec_tens/mins BCD
//   display; zero (all digits 0); running (RUN state); done (expiry pulse).
module countdown_timer #(
    parameter int MIN_DIGITS = 1,
    parameter int TICK_DIV   = 1
) (
    input  logic                    clock,
    input  logic                    clearn,
    input  logic [3:0]              digit,
    input  logic                    digit_valid,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    cancel,
    output logic [3:0]              sec_ones,
    output logic [3:0]              sec_tens,
    output logic [4*MIN_DIGITS-1:0] mins,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    localparam int MW = 4 * MIN_DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [3:0]    r_sec_ones;
    logic [3:0]    r_sec_tens;
    logic [MW-1:0] r_mins;
    logic [PW-1:0] r_presc;
    logic          r_done;

    logic          w_zero;
    logic          w_tick;
    logic          w_clear;
    logic          w_shift;
    logic          w_dec;
    logic          w_expire;
    logic          w_presc_clr;
    logic          w_presc_run;

    logic [3:0]    w_dec_ones;
    logic [3:0]    w_dec_tens;
    logic [MW-1:0] w_dec_mins;
    logic          w_dec_zero;
    logic          w_borrow;
    logic [MW-1:0] w_shift_mins;

`ifdef TIMER_ADD30_EN
    logic          w_add;
    logic          w_load30;
    logic          w_carry;
    logic [3:0]    w_add_ones;
    logic [3:0]    w_add_tens;
    logic [MW-1:0] w_add_mins;
`endif

    assign w_zero = (r_sec_ones == 4'd0) && (r_sec_tens == 4'd0) && (r_mins == '0);
    assign w_tick = (r_state == S_RUN) && (r_presc == P_LAST);
    assign w_presc_run = (r_state == S_RUN) && !cancel && !pause;

    // Keypad shift: the top minute digit falls off the end of the chain.
    assign w_shift_mins = MW'({r_mins, r_sec_tens});

    // One-second BCD decrement; sec_tens reloads to 5, minutes wrap 0->9.
    always_comb begin
        w_dec_ones = r_sec_ones - 4'd1;
        w_dec_tens = r_sec_tens;
        w_dec_mins = r_mins;
        w_borrow   = 1'b0;
        if (r_sec_ones == 4'd0) begin
            w_dec_ones = 4'd9;
            if (r_sec_tens == 4'd0) begin
                w_dec_tens = 4'd5;
                w_borrow   = 1'b1;
            end else begin
                w_dec_tens = r_sec_tens - 4'd1;
            end
        end
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (w_borrow) begin
                if (r_mins[4*i +: 4] == 4'd0) begin
                    w_dec_mins[4*i +: 4] = 4'd9;
                end else begin
                    w_dec_mins[4*i +: 4] = r_mins[4*i +: 4] - 4'd1;
                    w_borrow = 1'b0;
                end
            end
        end
        w_dec_zero = (w_dec_ones == 4'd0) && (w_dec_tens == 4'd0) &&
                     (w_dec_mins == '0);
    end

`ifdef TIMER_ADD30_EN
    // +30 s: tens+3 wraps by 6 into the minute chain, saturating at max.
    always_comb begin
        w_carry    = (r_sec_tens >= 4'd3);
        w_add_ones = r_sec_ones;
        w_add_tens = w_carry ? (r_sec_tens - 4'd3) : (r_sec_tens + 4'd3);
        w_add_mins = r_mins;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            if (w_carry) begin
                if (r_mins[4*i +: 4] >= 4'd9) begin
                    w_add_mins[4*i +: 4] = 4'd0;
                end else begin
                    w_add_mins[4*i +: 4] = r_mins[4*i +: 4] + 4'd1;
                    w_carry = 1'b0;
                end
            end
        end
        if (w_carry) begin
            w_add_mins = {MIN_DIGITS{4'h9}};
            w_add_tens = 4'd5;
            w_add_ones = 4'd9;
        end
    end
`endif

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_dec        = 1'b0;
        w_expire     = 1'b0;
        w_presc_clr  = 1'b0;
`ifdef TIMER_ADD30_EN
        w_add        = 1'b0;
        w_load30     = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (cancel) begin
                    w_clear = 1'b1;
                end else if (!pause) begin
                    if (start) begin
                        if (!w_zero) begin
                            w_next_state = S_RUN;
                            w_presc_clr  = 1'b1;
                        end
`ifdef TIMER_ADD30_EN
                        else begin
                            w_next_state = S_RUN;
                            w_presc_clr  = 1'b1;
                            w_load30     = 1'b1;
                        end
`endif
                    end else if (digit_valid && (digit <= 4'd9)) begin
                        w_shift = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (cancel) begin
                    w_next_state = S_IDLE;
                    w_clear      = 1'b1;
                end else if (pause) begin
                    w_next_state = S_PAUSED;
                end
`ifdef TIMER_ADD30_EN
                else if (start) begin
                    w_add = 1'b1;
                end
`endif
                else if (w_tick) begin
                    w_dec = 1'b1;
                    if (w_dec_zero) begin
                        w_next_state = S_IDLE;
                        w_expire     = 1'b1;
                    end
                end
            end
            S_PAUSED: begin
                if (cancel) begin
                    w_next_state = S_IDLE;
                    w_clear      = 1'b1;
                end else if (start) begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        running  = (r_state == S_RUN);
        done     = r_done;
        zero     = w_zero;
        sec_ones = r_sec_ones;
        sec_tens = r_sec_tens;
        mins     = r_mins;
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            r_sec_ones <= 4'd0;
            r_sec_tens <= 4'd0;
            r_mins     <= '0;
            r_presc    <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_expire;
            if (w_clear) begin
                r_sec_ones <= 4'd0;
                r_sec_tens <= 4'd0;
                r_mins     <= '0;
                r_presc    <= '0;
            end else begin
                if (w_presc_clr) begin
                    r_presc <= '0;
                end else if (w_presc_run) begin
                    r_presc <= (r_presc == P_LAST) ? '0 : r_presc + PW'(1);
                end
                if (w_shift) begin
                    r_sec_ones <= digit;
                    r_sec_tens <= r_sec_ones;
                    r_mins     <= w_shift_mins;
                end else if (w_dec) begin
                    r_sec_ones <= w_dec_ones;
                    r_sec_tens <= w_dec_tens;
                    r_mins     <= w_dec_mins;
                end
`ifdef TIMER_ADD30_EN
                else if (w_add) begin
                    r_sec_ones <= w_add_ones;
                    r_sec_tens <= w_add_tens;
                    r_mins     <= w_add_mins;
                end else if (w_load30) begin
                    r_sec_ones <= 4'd0;
                    r_sec_tens <= 4'd3;
                    r_mins     <= '0;
                end
`endif
            end
        end
    end

endmodule
